// File: rtl/video_sync_gen.sv
// ---------------------------------------------------------------------------
// video_sync_gen
//
// Purpose:
//   Turns the free-running absolute horizontal/vertical counters into
//   registered blanking and sync strobes. It also provides a latched
//   vertical-blank interrupt with a sticky overrun flag, and an 8-bit frame
//   counter. Every timing output is a decode of the counter values sampled
//   on a pixel-enabled MCLK edge, so all timing outputs share one enabled
//   cycle of latency.
//
// Configuration:
//   VIDEO_SYNC_GEN_CSYNC_EN - when defined, o_CSYNC_n is a registered
//   (o_HSYNC_n AND o_VSYNC_n). When undefined, o_CSYNC_n is tied high and no
//   composite sync logic is built.
//
// Ports:
//   i_EMU_MCLK         master clock, all state changes on its rising edge
//   i_EMU_RST          synchronous active-high reset
//   i_EMU_CLK6MPCEN_n  active-low 6 MHz pixel clock enable
//   i_ABS_H_CNTR[8:0]  absolute horizontal count (128..511)
//   i_ABS_V_CNTR[8:0]  absolute vertical count (220..511)
//   i_IRQ_ACK          CPU interrupt acknowledge, level, active-high
//   o_HBLANK_n         low during horizontal blanking
//   o_VBLANK_n         low during vertical blanking
//   o_BLANK_n          o_HBLANK_n AND o_VBLANK_n
//   o_HSYNC_n          horizontal sync, active-low
//   o_VSYNC_n          vertical sync, active-low
//   o_CSYNC_n          composite sync, active-low (see configuration)
//   o_VBLANK_IRQ_n     latched vertical blank interrupt, active-low
//   o_IRQ_OVERRUN      sticky: IRQ raised while one was already pending
//   o_FRAME_CNTR[7:0]  frame counter, wraps modulo 256
// ---------------------------------------------------------------------------
module video_sync_gen (
    input  logic       i_EMU_MCLK,
    input  logic       i_EMU_RST,
    input  logic       i_EMU_CLK6MPCEN_n,
    input  logic [8:0] i_ABS_H_CNTR,
    input  logic [8:0] i_ABS_V_CNTR,
    input  logic       i_IRQ_ACK,
    output logic       o_HBLANK_n,
    output logic       o_VBLANK_n,
    output logic       o_BLANK_n,
    output logic       o_HSYNC_n,
    output logic       o_VSYNC_n,
    output logic       o_CSYNC_n,
    output logic       o_VBLANK_IRQ_n,
    output logic       o_IRQ_OVERRUN,
    output logic [7:0] o_FRAME_CNTR
);

    logic pix_en;
    logic in_range;
    logic hblank_n_d;
    logic hsync_n_d;
    logic vblank_n_d;
    logic vsync_n_d;
    logic irq_set;
    logic frame_evt;

    assign pix_en = ~i_EMU_CLK6MPCEN_n;

    // Counter values below the documented ranges are treated as a fully
    // blanked, sync-free position. This keeps a mis-driven counter from
    // producing stray syncs or visible pixels.
    assign in_range = (i_ABS_H_CNTR >= 9'd128) && (i_ABS_V_CNTR >= 9'd220);

    // Combinational decode of the current counter position. The registers
    // below capture these values on enabled cycles.
    always_comb begin
        hblank_n_d = 1'b0;
        hsync_n_d  = 1'b1;
        vblank_n_d = 1'b0;
        vsync_n_d  = 1'b1;
        if (in_range) begin
            hblank_n_d = (i_ABS_H_CNTR >= 9'd256);
            hsync_n_d  = !((i_ABS_H_CNTR >= 9'd176) && (i_ABS_H_CNTR <= 9'd207));
            vblank_n_d = (i_ABS_V_CNTR >= 9'd272) && (i_ABS_V_CNTR <= 9'd495);
            vsync_n_d  = !((i_ABS_V_CNTR >= 9'd232) && (i_ABS_V_CNTR <= 9'd239));
        end
    end

    // Single-cycle events, each qualified by the pixel enable so that one
    // counter position fires exactly once.
    assign irq_set   = pix_en && (i_ABS_V_CNTR == 9'd496) && (i_ABS_H_CNTR == 9'd128);
    assign frame_evt = pix_en && (i_ABS_V_CNTR == 9'd220) && (i_ABS_H_CNTR == 9'd128);

    // Timing output registers. These hold their value on cycles without the
    // pixel enable, so downstream logic sees stable levels between pixels.
    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_RST) begin
            o_HBLANK_n <= 1'b0;
            o_VBLANK_n <= 1'b0;
            o_BLANK_n  <= 1'b0;
            o_HSYNC_n  <= 1'b1;
            o_VSYNC_n  <= 1'b1;
        end else if (pix_en) begin
            o_HBLANK_n <= hblank_n_d;
            o_VBLANK_n <= vblank_n_d;
            o_BLANK_n  <= hblank_n_d & vblank_n_d;
            o_HSYNC_n  <= hsync_n_d;
            o_VSYNC_n  <= vsync_n_d;
        end
    end

`ifdef VIDEO_SYNC_GEN_CSYNC_EN
    // Composite sync is built from the same pre-register decodes, so it
    // lines up exactly with o_HSYNC_n/o_VSYNC_n.
    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_RST) begin
            o_CSYNC_n <= 1'b1;
        end else if (pix_en) begin
            o_CSYNC_n <= hsync_n_d & vsync_n_d;
        end
    end
`else
    assign o_CSYNC_n = 1'b1;
`endif

    // Vertical blank interrupt latch. The set event has priority over the
    // acknowledge, so an IRQ raised on the same edge as a stale ack is never
    // lost. The acknowledge works on every MCLK edge, not only on pixel
    // edges, because the CPU runs independently of the pixel enable.
    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_RST) begin
            o_VBLANK_IRQ_n <= 1'b1;
            o_IRQ_OVERRUN  <= 1'b0;
        end else if (irq_set) begin
            o_VBLANK_IRQ_n <= 1'b0;
            if (!o_VBLANK_IRQ_n) begin
                o_IRQ_OVERRUN <= 1'b1;
            end
        end else if (i_IRQ_ACK) begin
            o_VBLANK_IRQ_n <= 1'b1;
        end
    end

    // Frame counter. It advances at the first pixel of the first vertical
    // line and wraps naturally at 8 bits.
    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_RST) begin
            o_FRAME_CNTR <= 8'd0;
        end else if (frame_evt) begin
            o_FRAME_CNTR <= o_FRAME_CNTR + 8'd1;
        end
    end

endmodule

// File: tb/tb_video_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_video_sync_gen
//
// Self-checking bench for video_sync_gen. The bench owns the H/V counters
// and can jump them directly to a position. A reference model computes the
// expected outputs from the timing rules: value ranges for blanking and sync,
// position events for the IRQ and frame counter. Whole-frame/line pixel
// counts are also compared against fixed totals.
// ---------------------------------------------------------------------------
module tb_video_sync_gen;

    logic       clk;
    logic       rst;
    logic       clk6m_en_n;
    logic [8:0] h_cnt;
    logic [8:0] v_cnt;
    logic       irq_ack;
    logic       hblank_n, vblank_n, blank_n, hsync_n, vsync_n, csync_n;
    logic       irq_n, irq_ovr;
    logic [7:0] frame_cntr;

    int checks;
    int failures;

    // Reference model state
    logic       m_hb, m_vb, m_bl, m_hs, m_vs, m_cs, m_irq_n, m_ovr;
    logic [7:0] m_frame;

    video_sync_gen dut (
        .i_EMU_MCLK       (clk),
        .i_EMU_RST        (rst),
        .i_EMU_CLK6MPCEN_n(clk6m_en_n),
        .i_ABS_H_CNTR     (h_cnt),
        .i_ABS_V_CNTR     (v_cnt),
        .i_IRQ_ACK        (irq_ack),
        .o_HBLANK_n       (hblank_n),
        .o_VBLANK_n       (vblank_n),
        .o_BLANK_n        (blank_n),
        .o_HSYNC_n        (hsync_n),
        .o_VSYNC_n        (vsync_n),
        .o_CSYNC_n        (csync_n),
        .o_VBLANK_IRQ_n   (irq_n),
        .o_IRQ_OVERRUN    (irq_ovr),
        .o_FRAME_CNTR     (frame_cntr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports tag/observed/expected on failure.
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: applies the timing rules to one MCLK edge.
    task automatic model_step(input logic r, input logic en, input logic ack,
                              input logic [8:0] h, input logic [8:0] v);
        logic valid;
        valid = (h >= 9'd128) && (v >= 9'd220);
        if (r) begin
            m_hb = 0; m_vb = 0; m_bl = 0; m_hs = 1; m_vs = 1; m_cs = 1;
            m_irq_n = 1; m_ovr = 0; m_frame = 8'd0;
        end else begin
            if (en) begin
                m_hb = valid && (h inside {[256:511]});
                m_vb = valid && (v inside {[272:495]});
                m_hs = !(valid && (h inside {[176:207]}));
                m_vs = !(valid && (v inside {[232:239]}));
                m_bl = m_hb && m_vb;
`ifdef VIDEO_SYNC_GEN_CSYNC_EN
                m_cs = m_hs && m_vs;
`else
                m_cs = 1'b1;
`endif
                if (v == 9'd220 && h == 9'd128) m_frame = m_frame + 8'd1;
            end
            if (en && v == 9'd496 && h == 9'd128) begin
                if (!m_irq_n) m_ovr = 1'b1;
                m_irq_n = 1'b0;
            end else if (ack) begin
                m_irq_n = 1'b1;
            end
        end
    endtask

    task automatic checkOutput();
        chk("hblank_n", {7'd0, hblank_n}, {7'd0, m_hb});
        chk("vblank_n", {7'd0, vblank_n}, {7'd0, m_vb});
        chk("blank_n",  {7'd0, blank_n},  {7'd0, m_bl});
        chk("hsync_n",  {7'd0, hsync_n},  {7'd0, m_hs});
        chk("vsync_n",  {7'd0, vsync_n},  {7'd0, m_vs});
        chk("csync_n",  {7'd0, csync_n},  {7'd0, m_cs});
        chk("irq_n",    {7'd0, irq_n},    {7'd0, m_irq_n});
        chk("irq_ovr",  {7'd0, irq_ovr},  {7'd0, m_ovr});
        chk("frame",    frame_cntr,       m_frame);
    endtask

    // Drive one MCLK cycle, then compare all outputs 1 ns after the edge.
    task automatic applyStimulus(input logic en, input logic ack, input logic r);
        clk6m_en_n = ~en;
        irq_ack    = ack;
        rst        = r;
        @(posedge clk);
        #1;
        model_step(r, en, ack, h_cnt, v_cnt);
        checkOutput();
        irq_ack = 1'b0;
        rst     = 1'b0;
    endtask

    // Place the counters at (h,v) and hold them until one enabled cycle has
    // sampled them. Random idle cycles are inserted before it.
    task automatic stepHV(input logic [8:0] h, input logic [8:0] v);
        int   tries;
        logic en;
        h_cnt = h;
        v_cnt = v;
        tries = 0;
        do begin
            en = (tries >= 4) || ($urandom_range(0, 3) != 0);
            applyStimulus(en, 1'b0, 1'b0);
            tries++;
        end while (!en);
    endtask

    task automatic advance();
        if (h_cnt == 9'd511) begin
            h_cnt = 9'd128;
            v_cnt = (v_cnt == 9'd511) ? 9'd220 : v_cnt + 9'd1;
        end else begin
            h_cnt = h_cnt + 9'd1;
        end
    endtask

    // Horizontal sample points per line for the sparse frame walk.
    logic [8:0] hpts [8] = '{9'd128, 9'd176, 9'd207, 9'd208, 9'd255, 9'd256, 9'd300, 9'd511};

    initial begin
        int vb_lines, vs_lines, hb_pix, hs_pix;
        logic en;
        checks = 0; failures = 0;
        h_cnt = 9'd128; v_cnt = 9'd220; irq_ack = 0; clk6m_en_n = 1; rst = 1;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);

        $display("[TB] two frames free-run (sparse H sampling)");
        for (int f = 0; f < 2; f++) begin
            vb_lines = 0; vs_lines = 0;
            for (int v = 220; v < 512; v++) begin
                for (int k = 0; k < 8; k++) begin
                    stepHV(hpts[k], 9'(v));
                    if (k == 6) begin
                        if (!vblank_n) vb_lines++;
                        if (!vsync_n)  vs_lines++;
                    end
                end
            end
            chk("vblank_lines", 8'(vb_lines), 8'd68);
            chk("vsync_lines",  8'(vs_lines), 8'd8);
        end
        chk("frame_after_2", frame_cntr, 8'd2);

        $display("[TB] full line pixel counts");
        for (int l = 0; l < 2; l++) begin
            hb_pix = 0; hs_pix = 0;
            for (int h = 128; h < 512; h++) begin
                stepHV(9'(h), 9'd300);
                if (!hblank_n) hb_pix++;
                if (!hsync_n)  hs_pix++;
            end
            chk("hblank_pixels", 8'(hb_pix), 8'd128);
            chk("hsync_pixels",  8'(hs_pix), 8'd32);
        end

        $display("[TB] hblank edge and enable hold");
        stepHV(9'd255, 9'd300);
        chk("hblank_at_255", {7'd0, hblank_n}, 8'd0);
        stepHV(9'd256, 9'd300);
        chk("hblank_at_256", {7'd0, hblank_n}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            h_cnt = 9'($urandom_range(128, 255));
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        chk("hblank_hold", {7'd0, hblank_n}, 8'd1);

        $display("[TB] out-of-range counters");
        for (int i = 0; i < 8; i++) begin
            if (i[0]) stepHV(9'($urandom_range(0, 127)), 9'($urandom_range(220, 511)));
            else      stepHV(9'($urandom_range(128, 511)), 9'($urandom_range(0, 219)));
        end

        $display("[TB] IRQ set and late acknowledge");
        applyStimulus(1'b0, 1'b0, 1'b1);
        stepHV(9'd128, 9'd496);
        chk("irq_set", {7'd0, irq_n}, 8'd0);
        h_cnt = 9'd129;
        for (int i = 0; i < 1000; i++) begin
            en = ($urandom_range(0, 1) != 0);
            applyStimulus(en, 1'b0, 1'b0);
            if (en) advance();
        end
        chk("irq_held", {7'd0, irq_n}, 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        chk("irq_acked", {7'd0, irq_n}, 8'd1);

        $display("[TB] set wins over ack, then overrun");
        h_cnt = 9'd128; v_cnt = 9'd496;
        applyStimulus(1'b1, 1'b1, 1'b0);
        chk("set_beats_ack", {7'd0, irq_n}, 8'd0);
        chk("no_overrun_yet", {7'd0, irq_ovr}, 8'd0);
        stepHV(9'd128, 9'd220);
        stepHV(9'd128, 9'd496);
        chk("overrun_set", {7'd0, irq_ovr}, 8'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        chk("irq_cleared", {7'd0, irq_n}, 8'd1);
        chk("overrun_sticky", {7'd0, irq_ovr}, 8'd1);

        $display("[TB] reset mid-frame and resume");
        h_cnt = 9'd300; v_cnt = 9'd300;
        applyStimulus(1'b1, 1'b0, 1'b1);
        stepHV(9'd301, 9'd300);
        chk("resume_hblank", {7'd0, hblank_n}, 8'd1);
        chk("resume_vblank", {7'd0, vblank_n}, 8'd1);

        $display("[TB] 256 frames wrap");
        for (int i = 0; i < 256; i++) begin
            stepHV(9'd128, 9'd220);
            if (i == 254) chk("frame_255", frame_cntr, 8'd255);
            stepHV(9'd129, 9'd220);
        end
        chk("frame_wrap", frame_cntr, 8'd0);
        stepHV(9'd128, 9'd496);
        chk("irq_before_rst", {7'd0, irq_n}, 8'd0);
        h_cnt = 9'd300; v_cnt = 9'd300;
        applyStimulus(1'b1, 1'b1, 1'b1);
        chk("rst_hblank", {7'd0, hblank_n}, 8'd0);
        chk("rst_vblank", {7'd0, vblank_n}, 8'd0);
        chk("rst_blank",  {7'd0, blank_n},  8'd0);
        chk("rst_hsync",  {7'd0, hsync_n},  8'd1);
        chk("rst_vsync",  {7'd0, vsync_n},  8'd1);
        chk("rst_csync",  {7'd0, csync_n},  8'd1);
        chk("rst_irq",    {7'd0, irq_n},    8'd1);
        chk("rst_ovr",    {7'd0, irq_ovr},  8'd0);
        chk("rst_frame",  frame_cntr,       8'd0);

        $display("[TB] composite sync");
        stepHV(9'd190, 9'd235);
`ifdef VIDEO_SYNC_GEN_CSYNC_EN
        chk("csync_in_sync", {7'd0, csync_n}, 8'd0);
`else
        chk("csync_in_sync", {7'd0, csync_n}, 8'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
